// File: rtl/vx_elastic_tracker_pkg.sv
// Shared constants and helpers for the elastic in-order completion tracker.
package vx_elastic_tracker_pkg;

  localparam int PERF_CTR_BITS = 44;

  function automatic int tag_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/vx_elastic_tracker.sv
// In-order tracker for operations that may complete out of order; retires in push order.
// Optional PERF_ELASTIC_TRACKER_EN adds saturating stall / busy-hold counters.
module vx_elastic_tracker
  import vx_elastic_tracker_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DATAW = 32,
  localparam int TAGW = tag_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [DATAW-1:0] data_in,
  output logic             strobe,
  output logic [TAGW-1:0]  strobe_tag,
  output logic [DATAW-1:0] strobe_data,
  input  logic             done,
  input  logic [TAGW-1:0]  done_tag,
  input  logic             busy,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [TAGW-1:0]  tag_out
`ifdef PERF_ELASTIC_TRACKER_EN
  ,
  output logic [PERF_CTR_BITS-1:0] perf_stalls,
  output logic [PERF_CTR_BITS-1:0] perf_busy_hold
`endif
);

  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int OFFW = TAGW + 1;
  localparam logic [CNTW-1:0] FULL    = CNTW'(DEPTH);
  localparam logic [TAGW-1:0] LAST    = TAGW'(DEPTH - 1);
  localparam logic [OFFW-1:0] DEPTH_W = OFFW'(DEPTH);

  logic [TAGW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [TAGW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic [DEPTH-1:0] done_q, done_d;
  logic             push, pop, head_done, done_ok;
  logic [OFFW-1:0]  done_off;

  assign ready_in    = (count_q != FULL);
  assign push        = valid_in && ready_in;
  assign strobe      = push;
  assign strobe_tag  = wr_ptr_q;
  assign strobe_data = data_in;

  assign head_done = (count_q != '0) && done_q[rd_ptr_q];
  assign valid_out = head_done && !busy;
  assign pop       = valid_out && ready_out;
  assign tag_out   = rd_ptr_q;

  // Distance of the completing slot from the head decides whether it is allocated.
  always_comb begin
    done_off = '0;
    if (done_tag >= rd_ptr_q) begin
      done_off = OFFW'(done_tag - rd_ptr_q);
    end else begin
      done_off = OFFW'(done_tag) + DEPTH_W - OFFW'(rd_ptr_q);
    end
  end

  assign done_ok = done && (OFFW'(done_tag) < DEPTH_W) &&
                   (done_off < OFFW'(count_q)) && !done_q[done_tag];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    done_d   = done_q;
    if (done_ok) begin
      done_d[done_tag] = 1'b1;
    end
    if (pop) begin
      done_d[rd_ptr_q] = 1'b0;
      rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + TAGW'(1);
    end
    if (push) begin
      done_d[wr_ptr_q] = 1'b0;
      wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + TAGW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      done_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      done_q   <= done_d;
    end
  end

`ifdef PERF_ELASTIC_TRACKER_EN
  logic [PERF_CTR_BITS-1:0] stalls_q, busy_hold_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stalls_q    <= '0;
      busy_hold_q <= '0;
    end else begin
      if (valid_in && !ready_in && (stalls_q != '1)) begin
        stalls_q <= stalls_q + PERF_CTR_BITS'(1);
      end
      if (head_done && busy && (busy_hold_q != '1)) begin
        busy_hold_q <= busy_hold_q + PERF_CTR_BITS'(1);
      end
    end
  end

  assign perf_stalls    = stalls_q;
  assign perf_busy_hold = busy_hold_q;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && done) begin
      assert (done_ok)
        else $error("vx_elastic_tracker: completion for unallocated or already-done tag %0d", done_tag);
    end
  end
`endif

endmodule

// File: tb/tb_vx_elastic_tracker.sv
// Bench for vx_elastic_tracker: queue-based reference for a DEPTH=4 instance plus
// directed literal checks on it and on a DEPTH=3 instance.
module tb_vx_elastic_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // DEPTH=4 instance
  logic        r4 = 1'b1, v4 = 1'b0, dn4 = 1'b0, b4 = 1'b0, ro4 = 1'b0;
  logic [15:0] d4 = '0;
  logic [1:0]  dt4 = '0;
  logic        ri4, s4, vo4;
  logic [1:0]  st4, to4;
  logic [15:0] sd4;

  // DEPTH=3 instance
  logic        r3 = 1'b1, v3 = 1'b0, dn3 = 1'b0, b3 = 1'b0, ro3 = 1'b0;
  logic [15:0] d3 = '0;
  logic [1:0]  dt3 = '0;
  logic        ri3, s3, vo3;
  logic [1:0]  st3, to3;
  logic [15:0] sd3;

`ifdef PERF_ELASTIC_TRACKER_EN
  logic [43:0] pst4, pbh4, pst3, pbh3;
`endif

  vx_elastic_tracker #(.DEPTH(4), .DATAW(16)) dut4 (
    .clk(clk), .reset(r4), .valid_in(v4), .ready_in(ri4), .data_in(d4),
    .strobe(s4), .strobe_tag(st4), .strobe_data(sd4),
    .done(dn4), .done_tag(dt4), .busy(b4),
    .valid_out(vo4), .ready_out(ro4), .tag_out(to4)
`ifdef PERF_ELASTIC_TRACKER_EN
    , .perf_stalls(pst4), .perf_busy_hold(pbh4)
`endif
  );

  vx_elastic_tracker #(.DEPTH(3), .DATAW(16)) dut3 (
    .clk(clk), .reset(r3), .valid_in(v3), .ready_in(ri3), .data_in(d3),
    .strobe(s3), .strobe_tag(st3), .strobe_data(sd3),
    .done(dn3), .done_tag(dt3), .busy(b3),
    .valid_out(vo3), .ready_out(ro3), .tag_out(to3)
`ifdef PERF_ELASTIC_TRACKER_EN
    , .perf_stalls(pst3), .perf_busy_hold(pbh3)
`endif
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Reference: outstanding tags in push order, completion flags per tag, next tag to issue.
  int q[$];
  bit mdn[4];
  int nxt = 0;
  int ps = 0, pb = 0;
  bit mdl_on = 1'b0;

  function automatic bit in_q(input int t);
    foreach (q[i]) if (q[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_ready();
    return q.size() != 4;
  endfunction

  function automatic bit m_head_done();
    return (q.size() != 0) && mdn[q[0]];
  endfunction

  always @(posedge clk) begin : mdl
    bit pu, po;
    if (r4) begin
      q.delete();
      foreach (mdn[i]) mdn[i] = 1'b0;
      nxt = 0; ps = 0; pb = 0;
      mdl_on = 1'b1;
    end else if (mdl_on) begin
      pu = v4 && m_ready();
      po = m_head_done() && !b4 && ro4;
      if (v4 && !m_ready()) ps++;
      if (m_head_done() && b4) pb++;
      if (dn4 && in_q(int'(dt4)) && !mdn[dt4]) mdn[dt4] = 1'b1;
      if (po) begin
        mdn[q[0]] = 1'b0;
        void'(q.pop_front());
      end
      if (pu) begin
        q.push_back(nxt);
        mdn[nxt] = 1'b0;
        nxt = (nxt + 1) % 4;
      end
    end
  end

  always @(negedge clk) begin : cmp
    bit e_rdy, e_vo;
    #1;
    if (mdl_on) begin
      e_rdy = m_ready();
      e_vo  = m_head_done() && !b4;
      chk("m.ready_in", int'(ri4), int'(e_rdy));
      chk("m.strobe", int'(s4), int'(v4 && e_rdy));
      if (v4 && e_rdy) begin
        chk("m.strobe_tag", int'(st4), nxt);
        chk("m.strobe_data", int'(sd4), int'(d4));
      end
      chk("m.valid_out", int'(vo4), int'(e_vo));
      chk("m.tag_out", int'(to4), (q.size() != 0) ? q[0] : nxt);
`ifdef PERF_ELASTIC_TRACKER_EN
      chk("m.perf_stalls", int'(pst4), ps);
      chk("m.perf_busy_hold", int'(pbh4), pb);
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef PERF_ELASTIC_TRACKER_EN
    logic [43:0] pb_start;
`endif
    repeat (2) step();
    r4 = 1'b0; r3 = 1'b0;
    #2;
    chk("rst.ready_in", int'(ri4), 1);
    chk("rst.valid_out", int'(vo4), 0);
    chk("rst.strobe", int'(s4), 0);
    chk("rst.tag_out", int'(to4), 0);
    chk("rst3.ready_in", int'(ri3), 1);
    chk("rst3.valid_out", int'(vo3), 0);

    // Fill to capacity, then hold valid_in against a full tracker.
    for (int i = 0; i < 4; i++) begin
      step(); v4 = 1'b1; d4 = 16'h100 + 16'(i);
      #2;
      chk("fill.strobe", int'(s4), 1);
      chk("fill.strobe_tag", int'(st4), i);
      chk("fill.strobe_data", int'(sd4), 'h100 + i);
    end
    step(); #2;
    chk("full.ready_in", int'(ri4), 0);
    chk("full.strobe", int'(s4), 0);
    step(); v4 = 1'b0;

    // Out-of-order completions 2,1,3 hold retirement until 0 finishes.
    step(); dn4 = 1'b1; dt4 = 2'd2;
    step(); dt4 = 2'd1; #2 chk("ooo.valid_out_a", int'(vo4), 0);
    step(); dt4 = 2'd3; #2 chk("ooo.valid_out_b", int'(vo4), 0);
    step(); dt4 = 2'd0; #2 chk("ooo.valid_out_c", int'(vo4), 0);
    step(); dn4 = 1'b0; ro4 = 1'b1;
    #2;
    chk("ooo.valid_out_d", int'(vo4), 1);
    chk("ooo.tag_out0", int'(to4), 0);
    for (int i = 1; i < 4; i++) begin
      step(); #2;
      chk("ooo.valid_out_run", int'(vo4), 1);
      chk("ooo.tag_out", int'(to4), i);
    end
    step(); ro4 = 1'b0; #2;
    chk("ooo.empty_valid_out", int'(vo4), 0);
    chk("ooo.empty_ready_in", int'(ri4), 1);

    // Full with head done: pop and push request in the same cycle.
    for (int i = 0; i < 4; i++) begin
      step(); v4 = 1'b1; d4 = 16'h200 + 16'(i);
    end
    step(); v4 = 1'b0; dn4 = 1'b1; dt4 = 2'd0;
    step(); dn4 = 1'b0; v4 = 1'b1; ro4 = 1'b1;
    #2;
    chk("wrap.valid_out", int'(vo4), 1);
    chk("wrap.tag_out", int'(to4), 0);
    chk("wrap.ready_in_same", int'(ri4), 0);
    chk("wrap.strobe_same", int'(s4), 0);
    step(); ro4 = 1'b0; #2;
    chk("wrap.ready_in_next", int'(ri4), 1);
    chk("wrap.strobe_next", int'(s4), 1);
    chk("wrap.strobe_tag", int'(st4), 0);
    step(); v4 = 1'b0; #2;
    chk("wrap.full_again", int'(ri4), 0);

    // Drain while completions overlap pops of other slots.
    ro4 = 1'b1;
    step(); dn4 = 1'b1; dt4 = 2'd1;
    step(); dt4 = 2'd2;
    step(); dt4 = 2'd3;
    step(); dt4 = 2'd0;
    step(); dn4 = 1'b0;
    step(); ro4 = 1'b0; #2;
    chk("drain.valid_out", int'(vo4), 0);
    chk("drain.ready_in", int'(ri4), 1);

    // Busy masks valid_out for three cycles after completion.
    step(); v4 = 1'b1; #2 chk("busy.strobe_tag", int'(st4), 1);
    step(); v4 = 1'b0; dn4 = 1'b1; dt4 = 2'd1; b4 = 1'b1; ro4 = 1'b1;
`ifdef PERF_ELASTIC_TRACKER_EN
    pb_start = pbh4;
`endif
    step(); dn4 = 1'b0; #2 chk("busy.valid_out_1", int'(vo4), 0);
    step(); #2 chk("busy.valid_out_2", int'(vo4), 0);
    step(); #2 chk("busy.valid_out_3", int'(vo4), 0);
    step(); b4 = 1'b0; #2;
    chk("busy.valid_out_release", int'(vo4), 1);
    chk("busy.tag_out", int'(to4), 1);
`ifdef PERF_ELASTIC_TRACKER_EN
    chk("busy.perf_busy_hold", int'(pbh4 - pb_start), 3);
`endif
    step(); ro4 = 1'b0; #2 chk("busy.after_pop", int'(vo4), 0);

    // Reset with two ops in flight and a completion pulse during reset.
    step(); v4 = 1'b1;
    step();
    step(); v4 = 1'b0; r4 = 1'b1; dn4 = 1'b1; dt4 = 2'd2;
    step(); r4 = 1'b0; dn4 = 1'b0; #2;
    chk("mid_rst.ready_in", int'(ri4), 1);
    chk("mid_rst.valid_out", int'(vo4), 0);
    chk("mid_rst.tag_out", int'(to4), 0);
    step(); v4 = 1'b1; #2;
    chk("mid_rst.strobe", int'(s4), 1);
    chk("mid_rst.strobe_tag", int'(st4), 0);
    step(); v4 = 1'b0;

    // DEPTH=3: seven single-op rounds across two wraps.
    for (int i = 0; i < 7; i++) begin
      step(); v3 = 1'b1; d3 = 16'(i);
      #2;
      chk("d3.strobe", int'(s3), 1);
      chk("d3.strobe_tag", int'(st3), i % 3);
      chk("d3.strobe_data", int'(sd3), i);
      step(); v3 = 1'b0; dn3 = 1'b1; dt3 = 2'(i % 3);
      #2 chk("d3.valid_out_pre", int'(vo3), 0);
      step(); dn3 = 1'b0; ro3 = 1'b1;
      #2;
      chk("d3.valid_out", int'(vo3), 1);
      chk("d3.tag_out", int'(to3), i % 3);
      step(); ro3 = 1'b0;
      #2;
      chk("d3.valid_out_post", int'(vo3), 0);
      chk("d3.ready_in", int'(ri3), 1);
    end

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
